inst_fetch: RTL
===============

# inst_fetch

Instruction-fetch stage of the RISC-V core: holds the fetch PC, issues reads to the synchronous instruction memory, and presents one instruction plus its PC per cycle to the decode stage, where the opcode, register and immediate fields are extracted. It absorbs decode back-pressure with a one-entry hold register, since memory read data is only valid for one cycle. It accepts PC redirects from the execute stage for taken branches, JAL and JALR, and squashes the wrong-path instruction.

## Interface
- RESET_PC, 32'h1000_0000, first byte address fetched after reset
- NOP_INST, 32'h0000_0013, instruction driven on inst_o whenever inst_valid_o=0 (addi x0,x0,0)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- stall_i  input  1  decode cannot accept the presented instruction this cycle
- redirect_i  input  1  execute resolved a control transfer; fetch restarts at redirect_pc_i
- redirect_pc_i  input  32  redirect target byte address; bits [1:0] ignored (treated as 0)
- imem_en_o  output  1  read strobe to instruction memory
- imem_addr_o  output  32  byte address of read; memory uses word index [15:2]
- imem_rdata_i  input  32  read data, valid only in the cycle after an enabled read
- inst_o  output  32  instruction presented to decode
- pc_o  output  32  byte address of inst_o
- inst_valid_o  output  1  inst_o is a real, non-squashed instruction

## Operation
- Registers: pc_q (next sequential fetch address), resp_pc_q (address of read issued last cycle), hold_inst_q, hold_pc_q, 2-bit state.
- Presentation states:
  - EMPTY: inst_o=NOP_INST, pc_o=resp_pc_q, inst_valid_o=0.
  - LIVE: inst_o=imem_rdata_i, pc_o=resp_pc_q, inst_valid_o=1.
  - HELD: inst_o=hold_inst_q, pc_o=hold_pc_q, inst_valid_o=1.
- Per-cycle decision, in priority order:
  - redirect_i=1: imem_en_o=1, imem_addr_o={redirect_pc_i[31:2],2'b00}; pc_q<=that+4; resp_pc_q<=that; next state LIVE; inst_valid_o forced 0 and inst_o=NOP_INST this cycle (wrong-path squash). Overrides stall_i.
  - stall_i=1: imem_en_o=0; pc_q held. LIVE->HELD capturing hold_inst_q<=imem_rdata_i, hold_pc_q<=resp_pc_q. HELD->HELD with registers unchanged. EMPTY->EMPTY.
  - otherwise: imem_en_o=1, imem_addr_o=pc_q; pc_q<=pc_q+4; resp_pc_q<=pc_q; next state LIVE from any state.
- imem_addr_o equals pc_q whenever imem_en_o=0, except it is 0 during reset.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000. Bits [1:0] of every issued address are 0.
- Decode consumes the presented instruction in any cycle with inst_valid_o=1 and stall_i=0.
- No instruction is duplicated or dropped across stalls; only a redirect discards instructions: the one presented that cycle and the read in flight.

## Timing
- While rst=1, regardless of clock: state=EMPTY, pc_q=RESET_PC, resp_pc_q=RESET_PC, hold registers 0.
- While rst=1, outputs: imem_en_o=0, imem_addr_o=0, inst_o=NOP_INST, pc_o=RESET_PC, inst_valid_o=0.
- First cycle after rst falls: imem_addr_o=RESET_PC with imem_en_o=1. The next cycle presents that instruction (LIVE).
- Fetch-to-present latency is 1 cycle. Sustained throughput is 1 instruction per cycle with no stall or redirect.
- Redirect penalty: in the redirect cycle, inst_valid_o=0. The target instruction is presented the following cycle.
- Stall release: HELD presents the hold register in the release cycle while the next sequential address is issued. Present-to-present gap is therefore 1 cycle, with no bubble.
- rst asserted mid-operation in any state clears everything immediately (asynchronous). The in-flight read data is ignored.

## Test plan
- Free-run: RESET_PC=32'h1000_0000, memory returns its address as data -> imem_addr_o 0x1000_0000, 0x1000_0004, 0x1000_0008 on consecutive cycles. inst_o/pc_o lag by one cycle with inst_valid_o=1 from the second cycle after reset.
- Stall: assert stall_i for 3 cycles while presenting 0x1000_0008 -> inst_o/pc_o hold 0x1000_0008 and imem_en_o=0 throughout. Release -> 0x1000_000C is issued and presented next, with no duplicate.
- Redirect: redirect_i=1, redirect_pc_i=32'h4000_0022 while presenting 0x1000_0004 -> same cycle inst_valid_o=0, inst_o=0x0000_0013, imem_addr_o=0x4000_0020. Next cycles present 0x4000_0020, then 0x4000_0024.
- Redirect plus stall in the same cycle, starting from HELD -> redirect wins, hold is discarded, and the target is presented next cycle.
- Wrap: redirect to 32'hFFFF_FFFC with no stall -> next issued address 32'h0000_0000.
- Asynchronous reset pulse mid-cycle while HELD -> outputs immediately take the reset values without waiting for a clock edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction-fetch stage.
//
// Holds the fetch PC, issues reads to a synchronous instruction memory and
// presents one instruction plus its PC per cycle to decode. Memory read data
// is only valid for the cycle after the read, so a one-entry hold register
// keeps the presented instruction alive while decode stalls. A redirect from
// execute restarts fetch at the target and squashes the instruction presented
// in the redirect cycle (the read in flight is simply never presented).
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   stall_i         decode cannot accept the presented instruction
//   redirect_i      restart fetch at redirect_pc_i (bits [1:0] ignored)
//   redirect_pc_i   redirect target byte address
//   imem_en_o       read strobe to instruction memory
//   imem_addr_o     read byte address (word aligned)
//   imem_rdata_i    read data, valid the cycle after an enabled read
//   inst_o, pc_o    presented instruction and its byte address
//   inst_valid_o    inst_o is a real, non-squashed instruction
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h1000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_en_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic        inst_valid_o
);

   // EMPTY: nothing to present; LIVE: memory data is the instruction;
   // HELD: the hold register is the instruction.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_LIVE  = 2'd1,
      S_HELD  = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc;          // next sequential fetch address
   logic [31:0] r_resp_pc;     // address of the read issued last cycle
   logic [31:0] r_hold_inst;
   logic [31:0] r_hold_pc;
   logic        w_capture;     // LIVE instruction must be saved before it vanishes
   logic [31:0] w_tgt;
   logic        w_unused_bits;

   assign w_tgt         = {redirect_pc_i[31:2], 2'b00};
   assign w_unused_bits = ^redirect_pc_i[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_capture    = 1'b0;
      imem_en_o    = 1'b0;
      imem_addr_o  = r_pc;
      inst_o       = NOP_INST;
      pc_o         = r_resp_pc;
      inst_valid_o = 1'b0;

      case (r_state)
         S_LIVE: begin
            inst_o       = imem_rdata_i;
            inst_valid_o = 1'b1;
         end
         S_HELD: begin
            inst_o       = r_hold_inst;
            pc_o         = r_hold_pc;
            inst_valid_o = 1'b1;
         end
         default: ;
      endcase

      if (rst) begin
         // State registers already sit at reset values; only the memory
         // port needs forcing, since it is driven by the decision logic.
         imem_addr_o = '0;
      end else if (redirect_i) begin
         // Wrong-path squash: whatever is presented now is discarded.
         imem_en_o    = 1'b1;
         imem_addr_o  = w_tgt;
         inst_o       = NOP_INST;
         inst_valid_o = 1'b0;
         w_state_nxt  = S_LIVE;
      end else if (stall_i) begin
         if (r_state == S_LIVE) begin
            w_state_nxt = S_HELD;
            w_capture   = 1'b1;
         end
      end else begin
         imem_en_o   = 1'b1;
         w_state_nxt = S_LIVE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_resp_pc   <= RESET_PC;
         r_hold_inst <= '0;
         r_hold_pc   <= '0;
      end else if (redirect_i) begin
         r_pc      <= w_tgt + 32'd4;
         r_resp_pc <= w_tgt;
      end else if (stall_i) begin
         if (w_capture) begin
            r_hold_inst <= imem_rdata_i;
            r_hold_pc   <= r_resp_pc;
         end
      end else begin
         r_pc      <= r_pc + 32'd4;
         r_resp_pc <= r_pc;
      end
   end

endmodule
